banco_registros: RTL and testbench

BANCO_REGISTROS -- requirements
Module: banco_registros

---
 rtl/banco_registros.sv | 57 +++++
 tb/tb_banco_registros.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/banco_registros.sv
// 32-entry register file with two combinational read ports, write-through bypass,
// a saturating effective-write counter and the index of the last effective write.
module banco_registros #(
  parameter int ANCHO_DATOS = 32,
  parameter int ANCHO_CONT  = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   RegWrite,
  input  logic [4:0]             DirEscritura,
  input  logic [ANCHO_DATOS-1:0] DatoEscritura,
  input  logic [4:0]             DirLectura1,
  input  logic [4:0]             DirLectura2,
  output logic [ANCHO_DATOS-1:0] DatoLectura1,
  output logic [ANCHO_DATOS-1:0] DatoLectura2,
  output logic [ANCHO_CONT-1:0]  NumEscrituras,
  output logic [4:0]             UltimaDir
);

  localparam logic [ANCHO_CONT-1:0] CONT_UNO = ANCHO_CONT'(1);

  logic [ANCHO_DATOS-1:0] regs [32];
  logic [ANCHO_CONT-1:0]  num_escrituras;
  logic [4:0]             ultima_dir;
  logic                   escritura_efectiva;

  // Reset wins over a simultaneous write, and index 0 is never a real destination.
  assign escritura_efectiva = RegWrite && !Reset && (DirEscritura != 5'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      num_escrituras <= '0;
      ultima_dir     <= '0;
    end else if (escritura_efectiva) begin
      regs[DirEscritura] <= DatoEscritura;
      ultima_dir         <= DirEscritura;
      if (num_escrituras != '1) begin
        num_escrituras <= num_escrituras + CONT_UNO;
      end
    end
  end

  // Index 0 is forced to zero so it reads correctly even before the first reset.
  assign DatoLectura1 = (DirLectura1 == 5'd0) ? '0 :
                        (escritura_efectiva && (DirLectura1 == DirEscritura)) ? DatoEscritura :
                        regs[DirLectura1];
  assign DatoLectura2 = (DirLectura2 == 5'd0) ? '0 :
                        (escritura_efectiva && (DirLectura2 == DirEscritura)) ? DatoEscritura :
                        regs[DirLectura2];

  assign NumEscrituras = num_escrituras;
  assign UltimaDir     = ultima_dir;

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: directed cases with literal expectations,
// randomized traffic against an array-based reference model, and a 2-bit counter instance.
module tb_banco_registros;

  logic        Clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  dir_escritura;
  logic [31:0] dato_escritura;
  logic [4:0]  dir_lectura1;
  logic [4:0]  dir_lectura2;
  logic [31:0] dato_lectura1;
  logic [31:0] dato_lectura2;
  logic [15:0] num_escrituras;
  logic [4:0]  ultima_dir;

  logic        s_reset;
  logic        s_reg_write;
  logic [4:0]  s_dir_escritura;
  logic [31:0] s_dato_escritura;
  logic [31:0] s_lectura1;
  logic [31:0] s_lectura2;
  logic [1:0]  s_num;
  logic [4:0]  s_ultima;

  int total = 0;
  int bad   = 0;

  banco_registros #(.ANCHO_DATOS(32), .ANCHO_CONT(16)) dut (
    .Clk(Clk), .Reset(reset), .RegWrite(reg_write),
    .DirEscritura(dir_escritura), .DatoEscritura(dato_escritura),
    .DirLectura1(dir_lectura1), .DirLectura2(dir_lectura2),
    .DatoLectura1(dato_lectura1), .DatoLectura2(dato_lectura2),
    .NumEscrituras(num_escrituras), .UltimaDir(ultima_dir)
  );

  banco_registros #(.ANCHO_DATOS(32), .ANCHO_CONT(2)) dut_sat (
    .Clk(Clk), .Reset(s_reset), .RegWrite(s_reg_write),
    .DirEscritura(s_dir_escritura), .DatoEscritura(s_dato_escritura),
    .DirLectura1(5'd1), .DirLectura2(5'd2),
    .DatoLectura1(s_lectura1), .DatoLectura2(s_lectura2),
    .NumEscrituras(s_num), .UltimaDir(s_ultima)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain array of register contents plus an unbounded write tally.
  logic [31:0] model_mem [32];
  int          model_writes = 0;
  logic [4:0]  model_last = '0;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (reg_write && !reset && dir_escritura != 5'd0 && dir_escritura == idx) return dato_escritura;
    return model_mem[idx];
  endfunction

  function automatic logic [15:0] exp_count();
    return (model_writes > 65535) ? 16'hFFFF : 16'(model_writes);
  endfunction

  always @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
      model_writes = 0;
      model_last   = 5'd0;
      model_valid  = 1'b1;
    end else if (reg_write && dir_escritura != 5'd0) begin
      model_mem[dir_escritura] = dato_escritura;
      model_writes = model_writes + 1;
      model_last   = dir_escritura;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model once it has seen a reset.
  always @(negedge Clk) begin
    if (model_valid) begin
      checkOutput("model_rd1", dato_lectura1, exp_read(dir_lectura1));
      checkOutput("model_rd2", dato_lectura2, exp_read(dir_lectura2));
      checkOutput("model_cnt", {16'd0, num_escrituras}, {16'd0, exp_count()});
      checkOutput("model_last", {27'd0, ultima_dir}, {27'd0, model_last});
    end
  end

  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wd,
                               input logic [31:0] data, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge Clk);
    #1;
    reset          = rst;
    reg_write      = we;
    dir_escritura  = wd;
    dato_escritura = data;
    dir_lectura1   = r1;
    dir_lectura2   = r2;
  endtask

  int exp_sat [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b1; reg_write = 1'b0; dir_escritura = '0; dato_escritura = '0;
    dir_lectura1 = '0; dir_lectura2 = '0;
    s_reset = 1'b1; s_reg_write = 1'b0; s_dir_escritura = '0; s_dato_escritura = '0;

    // Reset, then sweep every index on both ports.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      @(negedge Clk);
      checkOutput("reset_rd1", dato_lectura1, 32'd0);
      checkOutput("reset_rd2", dato_lectura2, 32'd0);
    end
    checkOutput("reset_cnt", {16'd0, num_escrituras}, 32'd0);
    checkOutput("reset_last", {27'd0, ultima_dir}, 32'd0);

    // Ordinary writes including index 31.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd31, 32'h00000007, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    @(negedge Clk);
    checkOutput("wr5", dato_lectura1, 32'hDEADBEEF);
    checkOutput("wr31", dato_lectura2, 32'h00000007);
    checkOutput("wr_cnt", {16'd0, num_escrituras}, 32'd2);
    checkOutput("wr_last", {27'd0, ultima_dir}, 32'd31);

    // Writes to index 0 are discarded and not counted.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    @(negedge Clk);
    checkOutput("r0_bypass", dato_lectura1, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
    @(negedge Clk);
    checkOutput("r0_read", dato_lectura1, 32'd0);
    checkOutput("r0_cnt", {16'd0, num_escrituras}, 32'd2);
    checkOutput("r0_last", {27'd0, ultima_dir}, 32'd31);

    // Same-cycle bypass on both ports.
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9);
    @(negedge Clk);
    checkOutput("byp_rd1", dato_lectura1, 32'h12345678);
    checkOutput("byp_rd2", dato_lectura2, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    @(negedge Clk);
    checkOutput("byp_stored", dato_lectura1, 32'h12345678);

    // Reset beats a simultaneous write; bypass is off while in reset.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3);
    @(negedge Clk);
    checkOutput("rst_nobyp", dato_lectura1, 32'h00000011);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9);
    @(negedge Clk);
    checkOutput("rst_r3", dato_lectura1, 32'd0);
    checkOutput("rst_r9", dato_lectura2, 32'd0);
    checkOutput("rst_cnt", {16'd0, num_escrituras}, 32'd0);

    // Narrow counter saturates at 3.
    @(posedge Clk); #1;
    s_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_reg_write = 1'b1; s_dir_escritura = 5'(k + 1); s_dato_escritura = 32'(k + 100);
      @(posedge Clk); #1;
      s_reg_write = 1'b0;
      @(negedge Clk);
      checkOutput("sat_cnt", {30'd0, s_num}, 32'(exp_sat[k]));
    end
    checkOutput("sat_last", {27'd0, s_ultima}, 32'd5);
    checkOutput("sat_r1", s_lectura1, 32'd100);

    // Randomized traffic with occasional resets, checked by the model process.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wd;
      logic [4:0] r1;
      logic [4:0] r2;
      wd = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), wd, $urandom, r1, r2);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
